// File: rtl/ti_sar_adc_model.sv
// Cycle-based model of a time-interleaved SAR ADC. A round-robin sequencer gives sample
// instants to WAYS trimmed bit-serial SAR sub-ADCs and assembles their codes into aligned frames.
module ti_sar_adc_model #(
  parameter int WAYS    = 8,
  parameter int BITS    = 9,
  parameter int SPACING = 2
) (
  input  logic                   clk,
  input  logic                   clkrst,
  input  logic [BITS+1:0]        vin,
  input  logic [WAYS-1:0]        way_en,
  input  logic [WAYS*8-1:0]      osp,
  input  logic [WAYS*8-1:0]      osm,
  output logic [WAYS*BITS-1:0]   adcout,
  output logic                   adcout_valid,
  output logic [WAYS-1:0]        way_done,
  output logic                   clkout_des
);

  localparam int CW = (SPACING > 1) ? $clog2(SPACING) : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int KW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int FW = $clog2(BITS + 2);
  // Signed sum width: wide enough for vin plus a full +/-255 trim at any BITS.
  localparam int SW = (BITS + 4 > 11) ? BITS + 4 : 11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  if (WAYS * SPACING < BITS + 1) begin : g_bad_params
    $fatal(1, "ti_sar_adc_model: WAYS*SPACING must be >= BITS+1");
  end

  logic [CW-1:0]        cnt;
  logic [WW-1:0]        wp;
  logic                 slot;
  logic [WAYS*BITS-1:0] codes;
  logic [FW-1:0]        fcnt;

  assign slot = (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge clkrst) begin
    if (clkrst) begin
      cnt <= '0;
      wp  <= '0;
    end else if (cnt == CW'(SPACING - 1)) begin
      cnt <= '0;
      wp  <= (wp == WW'(WAYS - 1)) ? '0 : wp + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic [0:0]             state;
    logic [BITS+1:0]        held;
    logic [BITS-1:0]        res;
    logic [BITS-1:0]        code;
    logic [KW-1:0]          k;
    logic                   done;
    logic signed [SW-1:0]   sum;
    logic [BITS+1:0]        clamped;
    logic [BITS-1:0]        trial;
    logic [BITS-1:0]        res_next;
    logic                   sample;

    assign sample = slot && (wp == WW'(i));

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
      sum     = $signed(SW'(vin) + SW'(osp[8*i +: 8]) - SW'(osm[8*i +: 8]));
      clamped = sum[BITS+1:0];
      if (sum[SW-1])
        clamped = '0;
      else if (|sum[SW-2:BITS+2])
        clamped = '1;
      trial    = res | (BITS'(1) << k);
      res_next = (held[BITS+1:2] >= trial) ? trial : res;
    end

    always_ff @(posedge clk or posedge clkrst) begin
      if (clkrst) begin
        state <= ST_IDLE;
        held  <= '0;
        res   <= '0;
        code  <= '0;
        k     <= '0;
        done  <= 1'b0;
      end else begin
        done <= 1'b0;
        if (!way_en[i]) begin
          state <= ST_IDLE;
          code  <= '0;
        end else if (state == ST_CONV) begin
          res <= res_next;
          if (k == '0) begin
            code  <= res_next;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            k <= k - 1'b1;
          end
        end else if (sample) begin
          held  <= clamped;
          res   <= '0;
          k     <= KW'(BITS - 1);
          state <= ST_CONV;
        end
      end
    end

    assign codes[BITS*i +: BITS] = code;
    assign way_done[i]           = done;
  end

  // Frame timer runs off way WAYS-1's sample slot regardless of that way's enable.
  always_ff @(posedge clk or posedge clkrst) begin
    if (clkrst) begin
      fcnt         <= '0;
      adcout       <= '0;
      adcout_valid <= 1'b0;
      clkout_des   <= 1'b0;
    end else begin
      adcout_valid <= 1'b0;
      if (fcnt == FW'(1)) begin
        adcout       <= codes;
        adcout_valid <= 1'b1;
        clkout_des   <= ~clkout_des;
      end
      if (slot && wp == WW'(WAYS - 1))
        fcnt <= FW'(BITS + 1);
      else if (fcnt != '0)
        fcnt <= fcnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_ti_sar_adc_model.sv
// Directed self-checking bench for ti_sar_adc_model at WAYS=8, BITS=9, SPACING=2.
module tb_ti_sar_adc_model;
  localparam int WAYS = 8;
  localparam int BITS = 9;
  localparam int SPACING = 2;

  logic                 clk = 1'b0;
  logic                 clkrst = 1'b1;
  logic [BITS+1:0]      vin;
  logic [WAYS-1:0]      way_en;
  logic [WAYS*8-1:0]    osp;
  logic [WAYS*8-1:0]    osm;
  logic [WAYS*BITS-1:0] adcout;
  logic                 adcout_valid;
  logic [WAYS-1:0]      way_done;
  logic                 clkout_des;

  int checks = 0;
  int errors = 0;
  int edge_no;
  int done_cnt [WAYS];
  bit ramp = 1'b0;
  int at;
  int at2;

  ti_sar_adc_model #(.WAYS(WAYS), .BITS(BITS), .SPACING(SPACING)) dut (
    .clk(clk), .clkrst(clkrst), .vin(vin), .way_en(way_en), .osp(osp), .osm(osm),
    .adcout(adcout), .adcout_valid(adcout_valid), .way_done(way_done), .clkout_des(clkout_des)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge clkrst)
    if (clkrst) edge_no <= 0;
    else        edge_no <= edge_no + 1;

  always @(negedge clk)
    if (!clkrst)
      for (int i = 0; i < WAYS; i++)
        if (way_done[i]) done_cnt[i]++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int code_of(input int i);
    return int'(adcout[BITS*i +: BITS]);
  endfunction

  task automatic start();
    clkrst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < WAYS; i++) done_cnt[i] = 0;
    clkrst = 1'b0;
    if (ramp) vin = 11'(4);
  endtask

  // Returns the edge index of the next adcout_valid, or -1 if none within limit.
  task automatic wait_valid(input int limit, output int found);
    found = -1;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (ramp) vin = 11'(4 * (edge_no + 1));
      if (adcout_valid) begin
        found = edge_no;
        break;
      end
    end
  endtask

  initial begin
    vin = 11'd1000;
    way_en = 8'hFF;
    osp = '0;
    osm = '0;
    repeat (3) @(negedge clk);
    check("rst_adcout", adcout, 0);
    check("rst_valid", adcout_valid, 0);
    check("rst_way_done", way_done, 0);
    check("rst_clkout", clkout_des, 0);

    // Constant input, all ways enabled
    start();
    wait_valid(60, at);
    check("first_frame_edge", at, 25);
    for (int i = 0; i < WAYS; i++) check($sformatf("const_code%0d", i), code_of(i), 250);
    check("clkout_after_f1", clkout_des, 1);
    wait_valid(40, at2);
    check("frame_gap", at2 - at, 16);
    check("clkout_after_f2", clkout_des, 0);
    check("done_cnt0", done_cnt[0], 2);
    check("done_cnt7", done_cnt[7], 2);

    // Reset asserted mid-frame at edge 10
    start();
    repeat (10) @(posedge clk);
    #1;
    check("wd_edge10", way_done, 8'h01);
    clkrst = 1'b1;
    #1;
    check("midrst_way_done", way_done, 0);
    check("midrst_adcout", adcout, 0);
    @(negedge clk);
    clkrst = 1'b0;
    wait_valid(60, at);
    check("midrst_first_frame", at, 25);
    check("midrst_code0", code_of(0), 250);

    // Per-way trim
    osp[3*8 +: 8] = 8'd20;
    osm[5*8 +: 8] = 8'd40;
    start();
    wait_valid(60, at);
    check("trim_code3", code_of(3), 255);
    check("trim_code5", code_of(5), 240);
    check("trim_code0", code_of(0), 250);

    // Saturation at both ends
    osp = '0;
    osm = '0;
    osp[7:0] = 8'd100;
    vin = 11'd2047;
    start();
    wait_valid(60, at);
    check("sat_hi_code0", code_of(0), 511);
    check("sat_hi_code1", code_of(1), 511);
    osp = '0;
    osm[7:0] = 8'd50;
    vin = 11'd5;
    start();
    wait_valid(60, at);
    check("sat_lo_code0", code_of(0), 0);
    check("sat_lo_code1", code_of(1), 1);

    // Disabled ways
    osm = '0;
    vin = 11'd1000;
    way_en = 8'hFD;
    start();
    wait_valid(60, at);
    check("dis1_code1_f1", code_of(1), 0);
    check("dis1_code0_f1", code_of(0), 250);
    wait_valid(40, at2);
    check("dis1_gap", at2 - at, 16);
    check("dis1_code1_f2", code_of(1), 0);
    check("dis1_done1", done_cnt[1], 0);
    check("dis1_done2", done_cnt[2], 2);
    way_en = 8'h7F;
    start();
    wait_valid(60, at);
    check("dis7_first_frame", at, 25);
    check("dis7_code7", code_of(7), 0);
    check("dis7_code6", code_of(6), 250);
    wait_valid(40, at2);
    check("dis7_gap", at2 - at, 16);

    // Ramp input: vin = 4*edge, so each code equals its sample edge index
    way_en = 8'hFF;
    ramp = 1'b1;
    start();
    wait_valid(60, at);
    for (int i = 0; i < WAYS; i++) check($sformatf("ramp_f1_code%0d", i), code_of(i), 1 + 2 * i);
    wait_valid(40, at2);
    for (int i = 0; i < WAYS; i++) check($sformatf("ramp_f2_code%0d", i), code_of(i), 17 + 2 * i);
    ramp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
